pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/branch/memory status in, stall/flush/status out.
// The slave modport is the controller's view; master is the pipeline's view.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic             ex_rmem_en_i;
  logic [4:0]       ex_wreg_addr_i;
  logic             id_branch_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             stall_if_o;
  logic             stall_id_o;
  logic             stall_ex_o;
  logic             stall_mem_o;
  logic             flush_if_o;
  logic             flush_id_o;
  logic             mem_err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    input  ex_rmem_en_i, ex_wreg_addr_i, id_branch_i, dmem_req_i, dmem_ack_i,
    output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    output flush_if_o, flush_id_o, mem_err_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    output ex_rmem_en_i, ex_wreg_addr_i, id_branch_i, dmem_req_i, dmem_ack_i,
    input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    input  flush_if_o, flush_id_o, mem_err_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / stall / flush controller with data-memory timeout detection.
// Optional performance counters are built only when PIPE_CTRL_PERF_CNT_EN is defined;
// otherwise the count outputs are tied to zero and no counter flops exist.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0]  StRun     = 2'd0;
  localparam logic [1:0]  StMemWait = 2'd1;
  localparam logic [1:0]  StErr     = 2'd2;
  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        ldu, mw;

  assign mw  = bus.dmem_req_i & ~bus.dmem_ack_i;
  assign ldu = bus.ex_rmem_en_i & (bus.ex_wreg_addr_i != 5'd0) &
               ((bus.id_rs1_used_i & (bus.id_rs1_addr_i == bus.ex_wreg_addr_i)) |
                (bus.id_rs2_used_i & (bus.id_rs2_addr_i == bus.ex_wreg_addr_i)));

  // Next-state logic and combinational control outputs; reset forces everything to 0.
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    bus.stall_if_o   = 1'b0;
    bus.stall_id_o   = 1'b0;
    bus.stall_ex_o   = 1'b0;
    bus.stall_mem_o  = 1'b0;
    bus.flush_if_o   = 1'b0;
    bus.flush_id_o   = 1'b0;
    bus.mem_err_o    = 1'b0;
    bus.state_o      = state_q;

    case (state_q)
      StRun: begin
        if (mw) begin
          {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.stall_mem_o} = 4'hF;
          state_d    = StMemWait;
          wait_cnt_d = 16'd1;
        end else if (ldu) begin
          // Branch operands depend on the load, so the redirect waits.
          bus.stall_if_o = 1'b1;
          bus.stall_id_o = 1'b1;
          bus.flush_id_o = 1'b1;
        end else if (bus.id_branch_i) begin
          bus.flush_if_o = 1'b1;
        end
      end
      StMemWait: begin
        if (!bus.dmem_ack_i) begin
          {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.stall_mem_o} = 4'hF;
          if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
          if (wait_cnt_q == TimeoutVal) state_d = StErr;
        end else begin
          state_d = StRun;
          if (ldu) begin
            bus.stall_if_o = 1'b1;
            bus.stall_id_o = 1'b1;
            bus.flush_id_o = 1'b1;
          end else if (bus.id_branch_i) begin
            bus.flush_if_o = 1'b1;
          end
        end
      end
      StErr: begin
        bus.mem_err_o   = 1'b1;
        bus.flush_if_o  = 1'b1;
        bus.flush_id_o  = 1'b1;
        bus.stall_mem_o = 1'b1;
        state_d         = StRun;
      end
      default: state_d = StRun;
    endcase

    if (!rst_n) begin
      bus.stall_if_o  = 1'b0;
      bus.stall_id_o  = 1'b0;
      bus.stall_ex_o  = 1'b0;
      bus.stall_mem_o = 1'b0;
      bus.flush_if_o  = 1'b0;
      bus.flush_id_o  = 1'b0;
      bus.mem_err_o   = 1'b0;
      bus.state_o     = StRun;
    end
  end

  // FSM state and memory-wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Performance counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.stall_if_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.flush_if_o) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o = rst_n ? stall_cnt_q : {CNT_W{1'b0}};
  assign bus.flush_cnt_o = rst_n ? flush_cnt_q : {CNT_W{1'b0}};
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (MEM_TIMEOUT=4). Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later, well before the next rising edge.
module tb_pipe_ctrl;
  localparam int unsigned CntW = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pipe_ctrl_if #(.CNT_W(CntW)) bus ();

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id, mem_err}
  function automatic logic [6:0] ctl();
    return {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.stall_mem_o,
            bus.flush_if_o, bus.flush_id_o, bus.mem_err_o};
  endfunction

  task automatic idle();
    bus.id_rs1_addr_i  = 5'd0;
    bus.id_rs2_addr_i  = 5'd0;
    bus.id_rs1_used_i  = 1'b0;
    bus.id_rs2_used_i  = 1'b0;
    bus.ex_rmem_en_i   = 1'b0;
    bus.ex_wreg_addr_i = 5'd0;
    bus.id_branch_i    = 1'b0;
    bus.dmem_req_i     = 1'b0;
    bus.dmem_ack_i     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.dmem_req_i = 1'b1; bus.id_branch_i = 1'b1;
    bus.ex_rmem_en_i = 1'b1; bus.ex_wreg_addr_i = 5'd3;
    bus.id_rs1_addr_i = 5'd3; bus.id_rs1_used_i = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (ctl() !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctl got=%b want=%b", ctl(), 7'b0);
    end
    n_checks++;
    if (bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d want=0", bus.state_o);
    end
    n_checks++;
    if (bus.stall_cnt_o !== '0 || bus.flush_cnt_o !== '0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== 7'b0 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_idle got=%b/%0d want=0/0", ctl(), bus.state_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_rmem_en_i = 1'b1; bus.ex_wreg_addr_i = 5'd5;
    bus.id_rs1_addr_i = 5'd5; bus.id_rs1_used_i = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== 7'b1100010) begin
      n_fail++; $display("FAIL ldu_rs1 got=%b want=%b", ctl(), 7'b1100010);
    end
    @(negedge clk);
    bus.ex_wreg_addr_i = 5'd0; bus.id_rs1_addr_i = 5'd0;
    #1;
    n_checks++;
    if (ctl() !== 7'b0) begin
      n_fail++; $display("FAIL ldu_x0 got=%b want=%b", ctl(), 7'b0);
    end
    @(negedge clk);
    bus.ex_wreg_addr_i = 5'd7; bus.id_rs1_addr_i = 5'd2;
    bus.id_rs2_addr_i = 5'd7; bus.id_rs2_used_i = 1'b1; bus.id_branch_i = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== 7'b1100010 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL ldu_rs2_branch got=%b/%0d want=%b/0", ctl(), bus.state_o, 7'b1100010);
    end
    @(negedge clk);
    bus.id_rs2_used_i = 1'b0; bus.id_branch_i = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== 7'b0) begin
      n_fail++; $display("FAIL ldu_unused got=%b want=%b", ctl(), 7'b0);
    end
    @(negedge clk);
    idle(); bus.id_rs1_used_i = 1'b1; bus.id_rs1_addr_i = 5'd5; bus.ex_wreg_addr_i = 5'd5;
    #1;
    n_checks++;
    if (ctl() !== 7'b0) begin
      n_fail++; $display("FAIL ldu_noload got=%b want=%b", ctl(), 7'b0);
    end
  endtask

  task automatic test_redirect();
    logic [CntW-1:0] exp_flush;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_flush = 1;
`else
    exp_flush = 0;
`endif
    do_reset();
    #1;
    n_checks++;
    if (bus.flush_cnt_o !== '0) begin
      n_fail++; $display("FAIL redir_cnt0 got=%0d want=0", bus.flush_cnt_o);
    end
    @(negedge clk);
    bus.id_branch_i = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== 7'b0000100) begin
      n_fail++; $display("FAIL redir_ctl got=%b want=%b", ctl(), 7'b0000100);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (bus.flush_cnt_o !== exp_flush || bus.stall_cnt_o !== '0) begin
      n_fail++; $display("FAIL redir_cnt got=%0d/%0d want=%0d/0",
                         bus.flush_cnt_o, bus.stall_cnt_o, exp_flush);
    end
  endtask

  task automatic test_memwait();
    logic [1:0]      exp_state [3];
    logic [CntW-1:0] exp_stall;
    exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    do_reset();
    bus.dmem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl() !== 7'b1111000 || bus.state_o !== exp_state[i]) begin
        n_fail++; $display("FAIL memwait_c%0d got=%b/%0d want=%b/%0d",
                           i, ctl(), bus.state_o, 7'b1111000, exp_state[i]);
      end
      @(negedge clk);
    end
    // Ack cycle: stalls drop, redirect is still honoured.
    bus.dmem_ack_i = 1'b1; bus.id_branch_i = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== 7'b0000100 || bus.state_o !== 2'd1) begin
      n_fail++; $display("FAIL memwait_ack got=%b/%0d want=%b/1", ctl(), bus.state_o, 7'b0000100);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (ctl() !== 7'b0 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL memwait_done got=%b/%0d want=0/0", ctl(), bus.state_o);
    end
    n_checks++;
    if (bus.stall_cnt_o !== exp_stall) begin
      n_fail++; $display("FAIL memwait_cnt got=%0d want=%0d", bus.stall_cnt_o, exp_stall);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.dmem_req_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ctl() !== 7'b1111000 || bus.state_o !== 2'd1) begin
        n_fail++; $display("FAIL timeout_wait%0d got=%b/%0d want=%b/1",
                           i, ctl(), bus.state_o, 7'b1111000);
      end
      @(negedge clk);
    end
    bus.dmem_req_i = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== 7'b0001111 || bus.state_o !== 2'd2) begin
      n_fail++; $display("FAIL timeout_err got=%b/%0d want=%b/2", ctl(), bus.state_o, 7'b0001111);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (ctl() !== 7'b0 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL timeout_run got=%b/%0d want=0/0", ctl(), bus.state_o);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.dmem_req_i = 1'b1; bus.id_branch_i = 1'b1;
    bus.ex_rmem_en_i = 1'b1; bus.ex_wreg_addr_i = 5'd9;
    bus.id_rs1_addr_i = 5'd9; bus.id_rs1_used_i = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== 7'b1111000) begin
      n_fail++; $display("FAIL prio_ctl got=%b want=%b", ctl(), 7'b1111000);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.state_o !== 2'd1) begin
      n_fail++; $display("FAIL prio_state got=%0d want=1", bus.state_o);
    end
  endtask

  task automatic test_reset_midwait();
    // Entered while the previous test leaves the FSM in MEMWAIT with req pending.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== 7'b0 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL rstwait_hold got=%b/%0d want=0/0", ctl(), bus.state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    n_checks++;
    if (ctl() !== 7'b0 || bus.state_o !== 2'd0 ||
        bus.stall_cnt_o !== '0 || bus.flush_cnt_o !== '0) begin
      n_fail++; $display("FAIL rstwait_after got=%b/%0d/%0d/%0d want=0/0/0/0",
                         ctl(), bus.state_o, bus.stall_cnt_o, bus.flush_cnt_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.mem_err_o !== 1'b0 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL rstwait_noerr got=%b/%0d want=0/0", bus.mem_err_o, bus.state_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_memwait();
    test_timeout();
    test_priority();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
